in_service_register: RTL
========================

Name: in_service_register

Overview:
- Stage directly downstream of Priority_Resolver in the 8259 PIC.
- Takes the resolver's chosen_interrupt and request-valid, raises INT to the CPU, and runs the two-pulse 8086 INTA handshake.
- Maintains the 8-bit In-Service Register (ISR) and returns a one-cycle clear to the IRR stage.
- Handles non-specific, specific and automatic EOI, and rotation of the lowest-priority pointer.

Parameters:
- NUM_IR, 8, number of interrupt lines (fixed 8; widths below assume 8).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- int_valid  input  1  resolver has an unmasked pending request
- chosen_interrupt  input  3  resolver's highest-priority pending level
- inta_n  input  1  CPU acknowledge, already synchronised to clk, active-low
- vector_base  input  5  ICW2 T7..T3
- aeoi  input  1  automatic-EOI mode
- eoi_cmd  input  1  one-cycle EOI command strobe from the control logic
- eoi_specific  input  1  qualifies eoi_cmd; 1 = specific EOI
- eoi_level  input  3  level for specific EOI
- rotate_en  input  1  rotate on EOI/AEOI
- isr  output  8  In-Service Register
- int_out  output  1  INT to CPU
- clear  output  1  one-cycle pulse telling IRR to clear clear_level
- clear_level  output  3  level to clear in IRR
- data_out  output  8  vector byte
- data_oe  output  1  data_out valid / bus drive enable
- lowest_priority  output  3  current lowest-priority level; feeds resolver rotation

Behaviour:
- Reset (async, reset=0):
  - isr=0, int_out=0, clear=0, clear_level=0, data_out=0, data_oe=0.
  - lowest_priority=7, giving fixed priority with IR0 highest.
  - State=IDLE.
- Priority rank: rank(n) = (n - lowest_priority - 1) mod 8; rank 0 is highest.
- Accept condition: int_valid=1 AND (isr==0 OR rank(chosen_interrupt) < rank of highest-priority ISR bit).
- INTA edges: fall = inta_n 1 in the previous cycle and 0 now; rise = 0 then 1.
- FSM states: IDLE, REQ, ACK1, ACK2.
  - IDLE: accept condition true -> REQ; int_out=1 registered in the same edge.
  - REQ, first fall:
    - Latch lvl = chosen_interrupt.
    - If int_valid=1: set isr[lvl]; pulse clear=1 with clear_level=lvl for exactly one cycle.
    - If int_valid=0 (spurious): lvl=7; no ISR set; no clear.
    - int_out=0 -> ACK1.
  - REQ, int_valid drops before any fall: int_out stays 1 and the spurious path is taken.
  - ACK1, second fall -> ACK2: data_out={vector_base, lvl}; data_oe=1 while in ACK2.
  - ACK2, rise:
    - data_oe=0.
    - If aeoi=1 and not spurious: clear isr[lvl]; if rotate_en=1, lowest_priority=lvl.
    - -> IDLE.
  - Latency: int_out rises one clk after the accept condition becomes true.
- EOI, applied in any state on eoi_cmd=1:
  - Non-specific: clear the highest-rank set ISR bit. No-op if isr==0.
  - Specific: clear isr[eoi_level].
  - If rotate_en=1 and a bit was cleared: lowest_priority = cleared level.
- Simultaneous events:
  - ISR set and EOI clear in the same cycle on different bits: both take effect.
  - Same bit: the set wins.
- clear is never asserted for two consecutive cycles.
- isr may hold multiple bits (nested service). int_out re-asserts only under the accept condition.
- Async reset mid-handshake: immediate return to reset values; a pending vector is lost.

Test Plan:
- Basic ack: reset, int_valid=1, chosen=3, two INTA pulses, vector_base=5'b00001 -> int_out=1; after 1st fall isr=8'h08, clear pulse 1 cycle with clear_level=3; data_out=8'h0B during 2nd pulse; after rise isr=8'h08, int_out=0.
- Nesting: isr=8'h08, then chosen=1 -> int_out=1; ack -> isr=8'h0A. Then chosen=5 with isr=8'h0A -> int_out stays 0.
- Non-specific EOI: isr=8'h0A, eoi_cmd non-specific -> isr=8'h08; again -> isr=8'h00; again -> no change.
- AEOI + rotate: aeoi=1, rotate_en=1, chosen=2, ack -> isr=0 after 2nd rise, lowest_priority=2, no EOI needed. Then IRR all ones -> resolver order starts at IR3.
- Spurious: int_valid drops after int_out=1, INTA x2 -> data_out={vector_base,3'b111}, isr unchanged, no clear pulse.
- Async reset asserted during ACK2 -> data_oe=0, isr=0, int_out=0, lowest_priority=7 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/in_service_register.sv
// in_service_register: 8259 In-Service Register stage with INT/INTA handshake,
// EOI/AEOI handling and lowest-priority rotation.
`default_nettype none

module in_service_register #(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_valid,
  input  logic [2:0]        chosen_interrupt,
  input  logic              inta_n,
  input  logic [4:0]        vector_base,
  input  logic              aeoi,
  input  logic              eoi_cmd,
  input  logic              eoi_specific,
  input  logic [2:0]        eoi_level,
  input  logic              rotate_en,
  output logic [NUM_IR-1:0] isr,
  output logic              int_out,
  output logic              clear,
  output logic [2:0]        clear_level,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic [2:0]        lowest_priority
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_ACK1 = 2'd2;
  localparam logic [1:0] S_ACK2 = 2'd3;

  logic [1:0]        r_state;
  logic              r_inta_d;
  logic [NUM_IR-1:0] r_isr;
  logic              r_int_out;
  logic              r_clear;
  logic [2:0]        r_clear_level;
  logic [7:0]        r_data_out;
  logic              r_data_oe;
  logic [2:0]        r_lp;
  logic [2:0]        r_lvl;
  logic              r_spur;

  logic              w_fall;
  logic              w_rise;
  logic              w_top_valid;
  logic [2:0]        w_top_lvl;
  logic [2:0]        w_top_rank;
  logic [2:0]        w_scan;
  logic [2:0]        w_chosen_rank;
  logic              w_accept;
  logic              w_eoi_hit;
  logic [2:0]        w_eoi_lvl;
  logic              w_set_en;
  logic              w_aeoi_en;
  logic [NUM_IR-1:0] w_set_mask;
  logic [NUM_IR-1:0] w_clr_mask;

  assign w_fall = r_inta_d & ~inta_n;
  assign w_rise = ~r_inta_d & inta_n;

  // Rank 0 sits just above the lowest-priority level; scan from rank 7 down so rank 0 wins.
  always_comb begin
    w_top_valid = 1'b0;
    w_top_lvl   = 3'd0;
    w_top_rank  = 3'd7;
    w_scan      = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      w_scan = r_lp + 3'd1 + 3'(k);
      if (r_isr[w_scan]) begin
        w_top_valid = 1'b1;
        w_top_lvl   = w_scan;
        w_top_rank  = 3'(k);
      end
    end
  end

  assign w_chosen_rank = chosen_interrupt - r_lp - 3'd1;
  assign w_accept      = int_valid & (~w_top_valid | (w_chosen_rank < w_top_rank));

  always_comb begin
    w_eoi_hit = 1'b0;
    w_eoi_lvl = 3'd0;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        w_eoi_lvl = eoi_level;
        w_eoi_hit = r_isr[eoi_level];
      end else begin
        w_eoi_lvl = w_top_lvl;
        w_eoi_hit = w_top_valid;
      end
    end
  end

  assign w_set_en   = (r_state == S_REQ) & w_fall & int_valid;
  assign w_aeoi_en  = (r_state == S_ACK2) & w_rise & aeoi & ~r_spur;
  assign w_set_mask = w_set_en ? (NUM_IR'(1) << chosen_interrupt) : '0;
  assign w_clr_mask = (w_eoi_hit ? (NUM_IR'(1) << w_eoi_lvl) : '0)
                    | (w_aeoi_en ? (NUM_IR'(1) << r_lvl) : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_inta_d      <= 1'b1;
      r_isr         <= '0;
      r_int_out     <= 1'b0;
      r_clear       <= 1'b0;
      r_clear_level <= 3'd0;
      r_data_out    <= 8'd0;
      r_data_oe     <= 1'b0;
      r_lp          <= 3'd7;
      r_lvl         <= 3'd7;
      r_spur        <= 1'b0;
    end else begin
      r_inta_d <= inta_n;
      r_clear  <= 1'b0;
      // Set is OR-ed after the clear so a same-bit set beats an EOI.
      r_isr    <= (r_isr & ~w_clr_mask) | w_set_mask;

      if (w_aeoi_en && rotate_en) begin
        r_lp <= r_lvl;
      end else if (w_eoi_hit && rotate_en) begin
        r_lp <= w_eoi_lvl;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_int_out <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_fall) begin
            r_int_out <= 1'b0;
            r_state   <= S_ACK1;
            if (int_valid) begin
              r_lvl         <= chosen_interrupt;
              r_spur        <= 1'b0;
              r_clear       <= 1'b1;
              r_clear_level <= chosen_interrupt;
            end else begin
              r_lvl  <= 3'd7;
              r_spur <= 1'b1;
            end
          end
        end
        S_ACK1: begin
          if (w_fall) begin
            r_data_out <= {vector_base, r_lvl};
            r_data_oe  <= 1'b1;
            r_state    <= S_ACK2;
          end
        end
        default: begin
          if (w_rise) begin
            r_data_oe <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign isr             = r_isr;
  assign int_out         = r_int_out;
  assign clear           = r_clear;
  assign clear_level     = r_clear_level;
  assign data_out        = r_data_out;
  assign data_oe         = r_data_oe;
  assign lowest_priority = r_lp;

endmodule

`default_nettype wire
